fft_peak_finder: RTL and testbench



---
 rtl/fft_peak_finder_if.sv | 26 ++
 rtl/fft_peak_finder.sv | 127 ++++++++++++
 tb/tb_fft_peak_finder.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/fft_peak_finder_if.sv
// rtl/fft_peak_finder_if.sv - RAM read port and peak result bundle for fft_peak_finder
interface fft_peak_finder_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic                       Start;
  logic [ADDR_W-1:0]          RdAddr;
  logic signed [DATA_W-1:0]   RdRe;
  logic signed [DATA_W-1:0]   RdIm;
  logic                       Busy;
  logic                       Valid;
  logic [ADDR_W-1:0]          PeakBin;
  logic [2*DATA_W:0]          PeakMag;

  // Peak finder side: issues read addresses, consumes RAM data, reports the peak
  modport master (
    input  Start, RdRe, RdIm,
    output RdAddr, Busy, Valid, PeakBin, PeakMag
  );

  // Environment side: FFT control, result RAM and result consumer
  modport slave (
    output Start, RdRe, RdIm,
    input  RdAddr, Busy, Valid, PeakBin, PeakMag
  );
endinterface

// File: rtl/fft_peak_finder.sv
// rtl/fft_peak_finder.sv - strongest-bin search over the lower half of the FFT result RAM (option: FFT_PEAK_MAG_SQUARED_EN)
module fft_peak_finder #(
  parameter int N_POINTS  = 256,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int FIRST_BIN = 1
) (
  input logic              Clk,
  input logic              Reset,
  fft_peak_finder_if.master bus
);

  localparam int                MAG_W      = 2*DATA_W+1;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(N_POINTS/2-1);
  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(FIRST_BIN);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] peak_bin_q, peak_bin_d;
  logic [MAG_W-1:0]  peak_mag_q, peak_mag_d;
  logic              cmp_en_q, cmp_en_d;
  logic              do_cmp;
  logic [ADDR_W-1:0] cmp_bin;
  logic [MAG_W-1:0]  mag;

`ifdef FFT_PEAK_MAG_SQUARED_EN
  // Power: squares are non-negative, so the full-width sum is taken as unsigned
  logic signed [2*DATA_W-1:0] re_ext, im_ext, re_sq, im_sq;
  assign re_ext = {{DATA_W{bus.RdRe[DATA_W-1]}}, bus.RdRe};
  assign im_ext = {{DATA_W{bus.RdIm[DATA_W-1]}}, bus.RdIm};
  assign re_sq  = re_ext * re_ext;
  assign im_sq  = im_ext * im_ext;
  assign mag    = {1'b0, re_sq} + {1'b0, im_sq};
`else
  // L1 magnitude: negating the most negative value wraps to the correct unsigned 2^(DATA_W-1)
  logic [DATA_W-1:0] abs_re, abs_im;
  logic [DATA_W:0]   mag_l1;
  assign abs_re = bus.RdRe[DATA_W-1] ? $unsigned(-bus.RdRe) : $unsigned(bus.RdRe);
  assign abs_im = bus.RdIm[DATA_W-1] ? $unsigned(-bus.RdIm) : $unsigned(bus.RdIm);
  assign mag_l1 = {1'b0, abs_re} + {1'b0, abs_im};
  assign mag    = {{(MAG_W-DATA_W-1){1'b0}}, mag_l1};
`endif

  // State register and all result/address registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      rd_addr_q  <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      peak_bin_q <= '0;
      peak_mag_q <= '0;
      cmp_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      peak_bin_q <= peak_bin_d;
      peak_mag_q <= peak_mag_d;
      cmp_en_q   <= cmp_en_d;
    end
  end

  // Next-state, address sweep and running-maximum update
  always_comb begin
    state_d    = state_q;
    rd_addr_d  = rd_addr_q;
    busy_d     = busy_q;
    valid_d    = valid_q;
    peak_bin_d = peak_bin_q;
    peak_mag_d = peak_mag_q;
    cmp_en_d   = cmp_en_q;
    do_cmp     = 1'b0;
    // RAM data lags the address by one cycle, so in SCAN it belongs to the previous address
    cmp_bin    = rd_addr_q - ADDR_W'(1);

    case (state_q)
      IDLE, DONE: begin
        if (bus.Start) begin
          state_d    = SCAN;
          rd_addr_d  = FIRST_ADDR;
          peak_bin_d = FIRST_ADDR;
          peak_mag_d = '0;
          busy_d     = 1'b1;
          valid_d    = 1'b0;
          cmp_en_d   = 1'b0;
        end
      end
      SCAN: begin
        // First SCAN edge sees data for the address issued before the scan; skip it
        do_cmp   = cmp_en_q;
        cmp_en_d = 1'b1;
        if (rd_addr_q == LAST_ADDR) begin
          state_d = DRAIN;
        end else begin
          rd_addr_d = rd_addr_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        do_cmp   = 1'b1;
        cmp_bin  = rd_addr_q;
        busy_d   = 1'b0;
        valid_d  = 1'b1;
        state_d  = DONE;
      end
      default: state_d = IDLE;
    endcase

    // Strictly greater keeps the lowest bin on ties
    if (do_cmp && (mag > peak_mag_q)) begin
      peak_mag_d = mag;
      peak_bin_d = cmp_bin;
    end
  end

  assign bus.RdAddr  = rd_addr_q;
  assign bus.Busy    = busy_q;
  assign bus.Valid   = valid_q;
  assign bus.PeakBin = peak_bin_q;
  assign bus.PeakMag = peak_mag_q;

endmodule

// File: tb/tb_fft_peak_finder.sv
// tb/tb_fft_peak_finder.sv - directed vector bench for fft_peak_finder
module tb_fft_peak_finder;

  logic Clk;
  logic Reset;

  fft_peak_finder_if #(.ADDR_W(8), .DATA_W(32)) ifc ();

  fft_peak_finder #(
    .N_POINTS(256), .ADDR_W(8), .DATA_W(32), .FIRST_BIN(1)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (ifc)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Synchronous-read result RAM model
  logic signed [31:0] mem_re [0:255];
  logic signed [31:0] mem_im [0:255];
  always @(posedge Clk) begin
    ifc.RdRe <= mem_re[ifc.RdAddr];
    ifc.RdIm <= mem_im[ifc.RdAddr];
  end

  typedef struct {
    int                 b0; logic signed [31:0] r0; logic signed [31:0] i0;
    int                 b1; logic signed [31:0] r1; logic signed [31:0] i1;
    int                 b2; logic signed [31:0] r2; logic signed [31:0] i2;
    int                 exp_bin;
    logic [64:0]        exp_l1;
    logic [64:0]        exp_sq;
  } vec_t;

  vec_t vecs [7];
  int   n_checks;
  int   n_fail;

  task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      mem_re[i] = '0;
      mem_im[i] = '0;
    end
  endtask

  task automatic put(input int b, input logic signed [31:0] re, input logic signed [31:0] im);
    if (b >= 0) begin
      mem_re[b] = re;
      mem_im[b] = im;
    end
  endtask

  task automatic load_vec(input vec_t v);
    clear_mem();
    put(v.b0, v.r0, v.i0);
    put(v.b1, v.r1, v.i1);
    put(v.b2, v.r2, v.i2);
  endtask

  function automatic logic [64:0] pick(input vec_t v);
`ifdef FFT_PEAK_MAG_SQUARED_EN
    return v.exp_sq;
`else
    return v.exp_l1;
`endif
  endfunction

  // One full scan: Start pulse, per-cycle Busy/RdAddr/Valid tracking, final result checks
  task automatic run_scan(input string nm, input int exp_bin, input logic [64:0] exp_mag, input int ign_k);
    int busy_cnt;
    int addr_err;
    int valid_k;
    int exp_addr;
    busy_cnt = 0;
    addr_err = 0;
    valid_k  = -1;
    @(negedge Clk);
    ifc.Start = 1'b1;
    @(negedge Clk);
    ifc.Start = 1'b0;
    chk({nm, " valid_low_after_start"}, 65'(ifc.Valid), 65'd0);
    for (int k = 0; k <= 130; k++) begin
      if (k > 0) begin
        @(negedge Clk);
        ifc.Start = (k == ign_k);
      end
      if (ifc.Busy) busy_cnt++;
      if (k <= 127) begin
        exp_addr = (k < 126) ? 1 + k : 127;
        if (int'(ifc.RdAddr) != exp_addr) addr_err++;
      end
      if (ifc.Valid && valid_k < 0) valid_k = k;
    end
    ifc.Start = 1'b0;
    chk({nm, " busy_cycles"}, 65'(busy_cnt), 65'd128);
    chk({nm, " addr_sweep_errors"}, 65'(addr_err), 65'd0);
    chk({nm, " valid_edge"}, 65'(valid_k), 65'd128);
    chk({nm, " peak_bin"}, 65'(ifc.PeakBin), 65'(exp_bin));
    chk({nm, " peak_mag"}, ifc.PeakMag, exp_mag);
    chk({nm, " busy_done"}, 65'(ifc.Busy), 65'd0);
  endtask

  initial begin
    int idle_err;
    n_checks  = 0;
    n_fail    = 0;
    Reset     = 1'b1;
    ifc.Start = 1'b0;
    clear_mem();

    vecs[0] = '{37, 1000, -500,   -1, 0, 0,   -1, 0, 0,   37, 65'd1500, 65'd1250000};
    vecs[1] = '{10, 300, 400,   90, 300, 400,   0, 10000, 0,   10, 65'd700, 65'd250000};
    vecs[2] = '{5, 32'sh8000_0000, 32'sh8000_0000,   -1, 0, 0,   -1, 0, 0,
                5, 65'h0_0000_0001_0000_0000, 65'h0_8000_0000_0000_0000};
    vecs[3] = '{-1, 0, 0,   -1, 0, 0,   -1, 0, 0,   1, 65'd0, 65'd0};
    vecs[4] = '{127, -7, 3,   1, 5, 4,   -1, 0, 0,   127, 65'd10, 65'd58};
    vecs[5] = '{1, 0, -9,   127, 4, 4,   -1, 0, 0,   1, 65'd9, 65'd81};
    vecs[6] = '{128, 5000, 0,   2, 1, 1,   0, -3000, 0,   2, 65'd2, 65'd2};

    // Reset, then idle with outputs at reset values
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    idle_err = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge Clk);
      if (ifc.Busy !== 1'b0 || ifc.Valid !== 1'b0 || ifc.RdAddr !== 8'd0 ||
          ifc.PeakBin !== 8'd0 || ifc.PeakMag !== 65'd0) idle_err++;
    end
    chk("idle_reset_values", 65'(idle_err), 65'd0);
    chk("idle_peak_mag", ifc.PeakMag, 65'd0);

    // Directed spectra
    for (int v = 0; v < 7; v++) begin
      load_vec(vecs[v]);
      run_scan($sformatf("vec%0d", v), vecs[v].exp_bin, pick(vecs[v]), -1);
    end

    // Start mid-scan is ignored
    load_vec(vecs[0]);
    run_scan("ignored_start", 37, pick(vecs[0]), 50);

    // Start from DONE restarts with new data
    mem_re[37] = '0; mem_im[37] = '0;
    mem_re[64] = 5;  mem_im[64] = 5;
`ifdef FFT_PEAK_MAG_SQUARED_EN
    run_scan("restart_from_done", 64, 65'd50, -1);
`else
    run_scan("restart_from_done", 64, 65'd10, -1);
`endif

    // Reset in the middle of a scan
    load_vec(vecs[0]);
    @(negedge Clk);
    ifc.Start = 1'b1;
    @(negedge Clk);
    ifc.Start = 1'b0;
    repeat (60) @(negedge Clk);
    chk("pre_reset_busy", 65'(ifc.Busy), 65'd1);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("midscan_reset_busy", 65'(ifc.Busy), 65'd0);
    chk("midscan_reset_valid", 65'(ifc.Valid), 65'd0);
    chk("midscan_reset_addr", 65'(ifc.RdAddr), 65'd0);
    chk("midscan_reset_bin", 65'(ifc.PeakBin), 65'd0);
    chk("midscan_reset_mag", ifc.PeakMag, 65'd0);
    run_scan("after_reset", 37, pick(vecs[0]), -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
